sd_resp_rx: RTL and testbench

Parametrised SPI-mode SD card response receiver. It samples DO (card MISO) once per clk, which is the SPI bit clock, and captures R1, R1b, R2 or R3/R7 responses right-aligned. It adds NCR start-bit timeout, R1b busy-wait with timeout, and a one-cycle valid handshake.
The command sender pulses start after the last command bit. Card init and read/write sequencers consume response, r1 and the flags.

---
 rtl/sd_pkg.sv | 46 ++++
 rtl/sd_resp_rx_if.sv | 32 +++
 rtl/sd_cycle_counter.sv | 41 ++++
 rtl/sd_resp_rx.sv | 143 ++++++++++++++
 tb/tb_sd_resp_rx.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
`default_nettype none
// ============================================================================
// Module : sd_pkg
// Purpose: Shared types and helpers for the SPI-mode SD response receiver.
//          Holds response-type encodings, the response length function,
//          R1 bit positions and the receiver state enum.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package sd_pkg;

  typedef enum logic [1:0] {
    RESP_R1   = 2'd0,
    RESP_R1B  = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3R7 = 2'd3
  } resp_type_e;

  // Bit positions inside the R1 byte
  localparam int R1_IDLE        = 0;
  localparam int R1_ERASE_RST   = 1;
  localparam int R1_ILLEGAL_CMD = 2;
  localparam int R1_CRC_ERR     = 3;
  localparam int R1_ERASE_SEQ   = 4;
  localparam int R1_ADDR_ERR    = 5;
  localparam int R1_PARAM_ERR   = 6;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_SHIFT      = 3'd2,
    ST_BUSY_WAIT  = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  // Number of response bits on the wire, start bit included
  function automatic logic [5:0] resp_len(input resp_type_e t);
    case (t)
      RESP_R2:   return 6'd16;
      RESP_R3R7: return 6'd40;
      default:   return 6'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/sd_resp_rx_if.sv
`default_nettype none
// ============================================================================
// Module : sd_resp_rx_if
// Purpose: Request/response bundle between a command sequencer and the
//          SD response receiver.
// Ports  : master - drives start/resp_type, observes result signals
//          slave  - the receiver side
// Rev    : 1.0  initial release
// ============================================================================
interface sd_resp_rx_if #(
  parameter int RESP_W = 40
);
  logic              start;
  logic [1:0]        resp_type;
  logic              busy;
  logic              resp_valid;
  logic [RESP_W-1:0] response;
  logic [7:0]        r1;
  logic              r1_err;
  logic              timeout;

  modport master (
    output start, resp_type,
    input  busy, resp_valid, response, r1, r1_err, timeout
  );

  modport slave (
    input  start, resp_type,
    output busy, resp_valid, response, r1, r1_err, timeout
  );
endinterface
`default_nettype wire

// File: rtl/sd_cycle_counter.sv
`default_nettype none
// ============================================================================
// Module : sd_cycle_counter
// Purpose: Free-running up counter with synchronous clear and a flag that
//          reports when the count equals a caller-supplied limit.
// Ports  : clk, reset       - clock and synchronous active-high reset
//          clear            - zero the count (priority over enable)
//          enable           - increment by one
//          limit[CNT_W]     - comparison value
//          at_limit         - count == limit
// Rev    : 1.0  initial release
// ============================================================================
module sd_cycle_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             at_limit
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + ONE;
    end
  end

  assign at_limit = (count == limit);

endmodule
`default_nettype wire

// File: rtl/sd_resp_rx.sv
`default_nettype none
// ============================================================================
// Module : sd_resp_rx
// Purpose: SPI-mode SD card response receiver. Waits for the start bit
//          (with NCR timeout), shifts in R1/R1b/R2/R3/R7 responses MSB first,
//          waits out R1b busy (with timeout) and reports the result with a
//          one-cycle resp_valid pulse.
// Ports  : clk, reset - bit clock, synchronous active-high reset
//          DO         - card MISO, idle high
//          bus        - slave side of sd_resp_rx_if (start, resp_type,
//                       busy, resp_valid, response, r1, r1_err, timeout)
// Rev    : 1.0  initial release
// ============================================================================
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int RESP_W   = 40,
  parameter int NCR_MAX  = 64,
  parameter int BUSY_MAX = 65535,
  parameter int CNT_W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         DO,
  sd_resp_rx_if.slave  bus
);

  localparam logic [CNT_W-1:0] NCR_LIM  = CNT_W'(NCR_MAX - 1);
  localparam logic [CNT_W-1:0] BUSY_LIM = CNT_W'(BUSY_MAX - 1);

  state_e            state;
  resp_type_e        type_q;
  logic [5:0]        bits_left;
  logic              busy_q;
  logic              valid_q;
  logic              timeout_q;
  logic [RESP_W-1:0] response_q;

  logic              cnt_clear;
  logic              cnt_enable;
  logic              cnt_at_limit;
  logic [CNT_W-1:0]  cnt_limit;
  logic              last_bit;
  logic [7:0]        r1_sel;

  assign last_bit = (state == ST_SHIFT) && (bits_left == 6'd1);

  // One counter serves both timeouts; it is cleared on entry to each
  // waiting state and only counts while the line shows "still waiting".
  assign cnt_clear  = ((state == ST_IDLE) && bus.start) || last_bit;
  assign cnt_enable = ((state == ST_WAIT_START) && DO) ||
                      ((state == ST_BUSY_WAIT) && !DO);
  assign cnt_limit  = (state == ST_BUSY_WAIT) ? BUSY_LIM : NCR_LIM;

  sd_cycle_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .limit    (cnt_limit),
    .at_limit (cnt_at_limit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      type_q     <= RESP_R1;
      bits_left  <= 6'd0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      response_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            type_q    <= resp_type_e'(bus.resp_type);
            timeout_q <= 1'b0;
            busy_q    <= 1'b1;
            state     <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (!DO) begin
            // The start bit is R1 bit 7, so it is kept as the first bit.
            response_q <= {{(RESP_W-1){1'b0}}, DO};
            bits_left  <= resp_len(type_q) - 6'd1;
            state      <= ST_SHIFT;
          end else if (cnt_at_limit) begin
            response_q <= '1;
            timeout_q  <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_SHIFT: begin
          response_q <= {response_q[RESP_W-2:0], DO};
          bits_left  <= bits_left - 6'd1;
          if (bits_left == 6'd1) begin
            state <= (type_q == RESP_R1B) ? ST_BUSY_WAIT : ST_DONE;
          end
        end
        ST_BUSY_WAIT: begin
          if (DO) begin
            state <= ST_DONE;
          end else if (cnt_at_limit) begin
            timeout_q <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // R1 sits in the most significant received byte of each format.
  always_comb begin
    r1_sel = response_q[7:0];
    case (type_q)
      RESP_R2:   r1_sel = response_q[15:8];
      RESP_R3R7: r1_sel = response_q[39:32];
      default:   r1_sel = response_q[7:0];
    endcase
  end

  assign bus.busy       = busy_q;
  assign bus.resp_valid = valid_q;
  assign bus.response   = response_q;
  assign bus.timeout    = timeout_q;
  assign bus.r1         = r1_sel;
  assign bus.r1_err     = |r1_sel[R1_PARAM_ERR:R1_ERASE_RST];

endmodule
`default_nettype wire

// File: tb/tb_sd_resp_rx.sv
`default_nettype none
// ============================================================================
// Module : tb_sd_resp_rx
// Purpose: Directed self-checking bench for sd_resp_rx (NCR_MAX=16,
//          BUSY_MAX=120). Each task drives one scenario and checks results
//          against hand-computed values.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sd_resp_rx;

  logic clk;
  logic reset;
  logic DO;
  int   checks;
  int   fails;

  sd_resp_rx_if #(.RESP_W(40)) bus ();

  sd_resp_rx #(
    .RESP_W   (40),
    .NCR_MAX  (16),
    .BUSY_MAX (120),
    .CNT_W    (16)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .DO    (DO),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Advance one clock; inputs set after this are sampled at the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] t);
    bus.start     = 1'b1;
    bus.resp_type = t;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic send_bits(input logic [39:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      DO = v[i];
      tick();
    end
    DO = 1'b1;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = -1;
    for (int k = 1; k <= bound; k++) begin
      tick();
      if (bus.resp_valid === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.resp_type = 2'd0;
    DO = 1'b1;
    repeat (3) tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.response !== 40'h0) begin fails++; $display("FAIL reset_response: got %h expected 0", bus.response); end
    checks++; if (bus.r1 !== 8'h00) begin fails++; $display("FAIL reset_r1: got %h expected 00", bus.r1); end
    checks++; if (bus.r1_err !== 1'b0) begin fails++; $display("FAIL reset_r1_err: got %b expected 0", bus.r1_err); end
    checks++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b expected 0", bus.timeout); end
    // reset wins over a simultaneous start
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    reset = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_with_start_busy: got %b expected 0", bus.busy); end
  endtask

  task automatic test_r1();
    int n;
    do_start(2'd0);
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL r1_busy_after_start: got %b expected 1", bus.busy); end
    DO = 1'b1;
    repeat (3) tick();
    send_bits(40'h01, 8);
    wait_valid(10, n);
    checks++; if (n != 1) begin fails++; $display("FAIL r1_latency: got %0d expected 1", n); end
    checks++; if (bus.response !== 40'h01) begin fails++; $display("FAIL r1_response: got %h expected 01", bus.response); end
    checks++; if (bus.r1 !== 8'h01) begin fails++; $display("FAIL r1_r1: got %h expected 01", bus.r1); end
    checks++; if (bus.r1_err !== 1'b0) begin fails++; $display("FAIL r1_r1_err: got %b expected 0", bus.r1_err); end
    checks++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL r1_timeout: got %b expected 0", bus.timeout); end
    tick();
    checks++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL r1_valid_pulse: got %b expected 0", bus.resp_valid); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL r1_busy_low: got %b expected 0", bus.busy); end
  endtask

  task automatic test_r3r7();
    int n;
    do_start(2'd3);
    repeat (2) tick();
    send_bits(40'h00_0000_01AA, 40);
    wait_valid(10, n);
    checks++; if (n != 1) begin fails++; $display("FAIL r3_latency: got %0d expected 1", n); end
    checks++; if (bus.response !== 40'h00_0000_01AA) begin fails++; $display("FAIL r3_response: got %h expected 00000001aa", bus.response); end
    checks++; if (bus.r1 !== 8'h00) begin fails++; $display("FAIL r3_r1: got %h expected 00", bus.r1); end
    checks++; if (bus.r1_err !== 1'b0) begin fails++; $display("FAIL r3_r1_err: got %b expected 0", bus.r1_err); end
    tick();
  endtask

  task automatic test_ncr_timeout();
    int n;
    do_start(2'd0);
    DO = 1'b1;
    wait_valid(40, n);
    checks++; if (n != 17) begin fails++; $display("FAIL ncr_latency: got %0d expected 17", n); end
    checks++; if (bus.timeout !== 1'b1) begin fails++; $display("FAIL ncr_timeout: got %b expected 1", bus.timeout); end
    checks++; if (bus.response !== 40'hFF_FFFF_FFFF) begin fails++; $display("FAIL ncr_response: got %h expected ffffffffff", bus.response); end
    checks++; if (bus.r1 !== 8'hFF) begin fails++; $display("FAIL ncr_r1: got %h expected ff", bus.r1); end
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin fails++; $display("FAIL ncr_idle: got busy=%b valid=%b expected 0/0", bus.busy, bus.resp_valid); end
  endtask

  task automatic test_r1b_ready();
    int n;
    bit saw;
    do_start(2'd1);
    tick();
    send_bits(40'h00, 8);
    DO = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b1) saw = 1'b1;
    end
    checks++; if (saw) begin fails++; $display("FAIL r1b_busy_hold: got early valid or busy drop expected none"); end
    DO = 1'b1;
    wait_valid(5, n);
    checks++; if (n != 2) begin fails++; $display("FAIL r1b_ready_latency: got %0d expected 2", n); end
    checks++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL r1b_ready_timeout: got %b expected 0", bus.timeout); end
    checks++; if (bus.response !== 40'h00) begin fails++; $display("FAIL r1b_ready_response: got %h expected 00", bus.response); end
    tick();
  endtask

  task automatic test_r1b_timeout();
    int n;
    do_start(2'd1);
    send_bits(40'h00, 8);
    DO = 1'b0;
    wait_valid(200, n);
    DO = 1'b1;
    checks++; if (n != 121) begin fails++; $display("FAIL r1b_to_latency: got %0d expected 121", n); end
    checks++; if (bus.timeout !== 1'b1) begin fails++; $display("FAIL r1b_to_timeout: got %b expected 1", bus.timeout); end
    checks++; if (bus.response !== 40'h00) begin fails++; $display("FAIL r1b_to_response: got %h expected 00", bus.response); end
    tick();
  endtask

  task automatic test_r2_err();
    int n;
    bit saw;
    logic [15:0] v;
    v = 16'h0400;
    do_start(2'd2);
    tick();
    for (int i = 15; i >= 0; i--) begin
      DO = v[i];
      bus.start = (i == 8);
      tick();
    end
    bus.start = 1'b0;
    DO = 1'b1;
    wait_valid(10, n);
    checks++; if (n != 1) begin fails++; $display("FAIL r2_latency: got %0d expected 1", n); end
    checks++; if (bus.response !== 40'h0400) begin fails++; $display("FAIL r2_response: got %h expected 0400", bus.response); end
    checks++; if (bus.r1 !== 8'h04) begin fails++; $display("FAIL r2_r1: got %h expected 04", bus.r1); end
    checks++; if (bus.r1_err !== 1'b1) begin fails++; $display("FAIL r2_r1_err: got %b expected 1", bus.r1_err); end
    checks++; if (bus.timeout !== 1'b0) begin fails++; $display("FAIL r2_timeout: got %b expected 0", bus.timeout); end
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) saw = 1'b1;
    end
    checks++; if (saw) begin fails++; $display("FAIL r2_start_ignored: got activity after done expected idle"); end
  endtask

  task automatic test_reset_mid_shift();
    int n;
    do_start(2'd0);
    tick();
    send_bits(40'h7, 4);
    checks++; if (bus.response !== 40'h7) begin fails++; $display("FAIL mid_partial_response: got %h expected 07", bus.response); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_reset_ctrl: got busy=%b valid=%b expected 0/0", bus.busy, bus.resp_valid); end
    checks++; if (bus.response !== 40'h0 || bus.r1 !== 8'h00 || bus.timeout !== 1'b0) begin fails++; $display("FAIL mid_reset_data: got resp=%h r1=%h to=%b expected 0", bus.response, bus.r1, bus.timeout); end
    repeat (3) tick();
    checks++; if (bus.resp_valid !== 1'b0) begin fails++; $display("FAIL mid_no_valid: got %b expected 0", bus.resp_valid); end
    do_start(2'd0);
    send_bits(40'h01, 8);
    wait_valid(10, n);
    checks++; if (n != 1 || bus.response !== 40'h01) begin fails++; $display("FAIL mid_recover: got n=%0d resp=%h expected 1/01", n, bus.response); end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    do_start(2'd0);
    send_bits(40'h04, 8);
    wait_valid(10, n);
    checks++; if (n != 1 || bus.r1_err !== 1'b1) begin fails++; $display("FAIL b2b_first: got n=%0d err=%b expected 1/1", n, bus.r1_err); end
    do_start(2'd0);
    checks++; if (bus.busy !== 1'b1 || bus.resp_valid !== 1'b0) begin fails++; $display("FAIL b2b_accept: got busy=%b valid=%b expected 1/0", bus.busy, bus.resp_valid); end
    send_bits(40'h00, 8);
    wait_valid(10, n);
    checks++; if (n != 1 || bus.response !== 40'h00 || bus.r1_err !== 1'b0) begin fails++; $display("FAIL b2b_second: got n=%0d resp=%h err=%b expected 1/00/0", n, bus.response, bus.r1_err); end
    tick();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    DO     = 1'b1;
    bus.start = 1'b0;
    bus.resp_type = 2'd0;
    test_reset();
    test_r1();
    test_r3r7();
    test_ncr_timeout();
    test_r1b_ready();
    test_r1b_timeout();
    test_r2_err();
    test_reset_mid_shift();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire
